// File: rtl/mas_lane_scheduler.sv
// Beat scheduler for an array of 8-bit serializer lanes: latches one beat, pulses the enabled lanes,
// waits for their busy handshake and counts frames. Define MAS_SCHED_TIMEOUT_EN for the watchdog.
module mas_lane_scheduler #(
  parameter int unsigned NUM_LANES   = 5,
  parameter int unsigned TIMEOUT_CYC = 64
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   s_valid,
  output logic                   s_ready,
  input  logic [8*NUM_LANES-1:0] s_data,
  input  logic                   s_last,
  input  logic [NUM_LANES-1:0]   cfg_lane_en,
  input  logic [NUM_LANES-1:0]   lvds_busy,
  input  logic                   err_clr,
  output logic [8*NUM_LANES-1:0] data_o,
  output logic [NUM_LANES-1:0]   start_o,
  output logic [NUM_LANES-1:0]   st_flag_o,
  output logic                   end_flag_o,
  output logic [15:0]            frame_cnt_o,
  output logic                   err_o
);

  typedef enum logic [2:0] {
    StIdle, StStart, StWaitBusy, StWaitDone, StEnd, StErr
  } state_e;

  state_e               state_q;
  logic [NUM_LANES-1:0] mask_q;
  logic                 last_q;
  logic                 first_q;
  logic [15:0]          frame_cnt_q;
  logic                 all_busy;
  logic                 none_busy;
  logic                 accept;
  logic                 timeout;

  // Only the lanes latched at accept take part in the handshake.
  assign all_busy    = (lvds_busy & mask_q) == mask_q;
  assign none_busy   = (lvds_busy & mask_q) == '0;
  assign s_ready     = (state_q == StIdle) && ((lvds_busy & cfg_lane_en) == '0) &&
                       (cfg_lane_en != '0);
  assign accept      = s_valid && s_ready;
  assign frame_cnt_o = frame_cnt_q;

`ifdef MAS_SCHED_TIMEOUT_EN
  localparam int unsigned WdW = $clog2(TIMEOUT_CYC + 1);

  logic [WdW-1:0] wdog_q;
  logic           err_q;

  // Expires on the TIMEOUT_CYC-th cycle spent waiting without progress.
  assign timeout = (wdog_q == WdW'(TIMEOUT_CYC - 1)) &&
                   (((state_q == StWaitBusy) && !all_busy) ||
                    ((state_q == StWaitDone) && !none_busy));
  assign err_o   = err_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wdog_q <= '0;
    end else if ((state_q == StStart) || ((state_q == StWaitBusy) && all_busy)) begin
      wdog_q <= '0;
    end else if ((state_q == StWaitBusy) || (state_q == StWaitDone)) begin
      wdog_q <= wdog_q + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      err_q <= 1'b0;
    end else if (timeout) begin
      err_q <= 1'b1;
    end else if ((state_q == StErr) && err_clr) begin
      err_q <= 1'b0;
    end
  end
`else
  localparam int unsigned unused_timeout_cyc = TIMEOUT_CYC;

  assign timeout = 1'b0;
  assign err_o   = 1'b0;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= StIdle;
      data_o      <= '0;
      mask_q      <= '0;
      last_q      <= 1'b0;
      first_q     <= 1'b1;
      start_o     <= '0;
      st_flag_o   <= '0;
      end_flag_o  <= 1'b0;
      frame_cnt_q <= '0;
    end else begin
      start_o    <= '0;
      st_flag_o  <= '0;
      end_flag_o <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (accept) begin
            data_o    <= s_data;
            mask_q    <= cfg_lane_en;
            last_q    <= s_last;
            start_o   <= cfg_lane_en;
            st_flag_o <= first_q ? cfg_lane_en : '0;
            first_q   <= 1'b0;
            state_q   <= StStart;
          end
        end
        StStart: state_q <= StWaitBusy;
        StWaitBusy: begin
          if (all_busy) begin
            state_q <= StWaitDone;
          end else if (timeout) begin
            state_q <= StErr;
          end
        end
        StWaitDone: begin
          if (none_busy) begin
            if (last_q) begin
              state_q     <= StEnd;
              end_flag_o  <= 1'b1;
              frame_cnt_q <= frame_cnt_q + 16'd1;
              first_q     <= 1'b1;
            end else begin
              state_q <= StIdle;
            end
          end else if (timeout) begin
            state_q <= StErr;
          end
        end
        StEnd: state_q <= StIdle;
        StErr: begin
          if (err_clr) begin
            state_q <= StIdle;
            first_q <= 1'b1;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_mas_lane_scheduler.sv
// Randomized self-checking bench for mas_lane_scheduler with a transaction-level reference model
// and per-lane serializer responders.
module tb_mas_lane_scheduler;

  localparam int NL = 5;
  localparam int DW = 8 * NL;
  localparam int TO = 64;

  logic          clk = 1'b0;
  logic          reset;
  logic          s_valid;
  logic          s_ready;
  logic [DW-1:0] s_data;
  logic          s_last;
  logic [NL-1:0] cfg_lane_en;
  logic [NL-1:0] lvds_busy;
  logic          err_clr;
  logic [DW-1:0] data_o;
  logic [NL-1:0] start_o;
  logic [NL-1:0] st_flag_o;
  logic          end_flag_o;
  logic [15:0]   frame_cnt_o;
  logic          err_o;

  always #5 clk = ~clk;

  mas_lane_scheduler #(
    .NUM_LANES  (NL),
    .TIMEOUT_CYC(TO)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .s_valid    (s_valid),
    .s_ready    (s_ready),
    .s_data     (s_data),
    .s_last     (s_last),
    .cfg_lane_en(cfg_lane_en),
    .lvds_busy  (lvds_busy),
    .err_clr    (err_clr),
    .data_o     (data_o),
    .start_o    (start_o),
    .st_flag_o  (st_flag_o),
    .end_flag_o (end_flag_o),
    .frame_cnt_o(frame_cnt_o),
    .err_o      (err_o)
  );

  int checks   = 0;
  int failures = 0;

  // Reference model: a beat is in flight from accept until every masked lane has been busy and
  // then idle again; a last beat adds one end-of-frame cycle.
  logic [DW-1:0] m_data;
  logic [NL-1:0] m_mask, m_start, m_st;
  logic          m_end, m_err, m_first, m_last;
  logic [15:0]   m_cnt;
  bit            m_beat, m_started, m_up, m_eof, m_accepted;
  int            m_wait;

  // Serializer responders.
  int rise[NL], fall[NL], ctr[NL];
  bit act[NL], dead[NL];
  bit noise_en, use_dir;
  int dir_rise, dir_fall;

  task automatic chk(input string name, input logic [63:0] act_v, input logic [63:0] exp_v);
    checks++;
    if (act_v !== exp_v) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act_v, exp_v);
    end
  endtask

  task automatic fail_bound(input string name);
    checks++;
    failures++;
    $display("FAIL %s actual=bound_expired required=event", name);
  endtask

  function automatic bit model_ready();
    return !m_beat && !m_eof && !m_err && ((lvds_busy & cfg_lane_en) == '0) &&
           (cfg_lane_en != '0);
  endfunction

  task automatic model_reset();
    m_data = '0; m_mask = '0; m_start = '0; m_st = '0; m_end = 1'b0; m_err = 1'b0;
    m_first = 1'b1; m_last = 1'b0; m_cnt = '0;
    m_beat = 0; m_started = 0; m_up = 0; m_eof = 0; m_accepted = 0; m_wait = 0;
  endtask

  task automatic model_waited();
    m_wait++;
`ifdef MAS_SCHED_TIMEOUT_EN
    if (m_wait >= TO) begin
      m_err  = 1'b1;
      m_beat = 0;
    end
`endif
  endtask

  // Predicts the registered outputs after the coming rising edge from the current inputs.
  task automatic model_step();
    bit rdy;
    rdy = model_ready();
    m_start = '0; m_st = '0; m_end = 1'b0; m_accepted = 0;
    if (m_err) begin
      if (err_clr) begin
        m_err   = 1'b0;
        m_first = 1'b1;
      end
    end else if (m_eof) begin
      m_eof = 0;
    end else if (!m_beat) begin
      if (s_valid && rdy) begin
        m_data = s_data; m_mask = cfg_lane_en; m_last = s_last;
        m_start = cfg_lane_en;
        m_st = m_first ? cfg_lane_en : '0;
        m_first = 1'b0;
        m_beat = 1; m_started = 0; m_up = 0; m_accepted = 1;
      end
    end else if (!m_started) begin
      m_started = 1;
      m_wait    = 0;
    end else if (!m_up) begin
      if ((lvds_busy & m_mask) == m_mask) begin
        m_up   = 1;
        m_wait = 0;
      end else begin
        model_waited();
      end
    end else begin
      if ((lvds_busy & m_mask) == '0) begin
        m_beat = 0;
        if (m_last) begin
          m_end = 1'b1; m_cnt = m_cnt + 16'd1; m_eof = 1; m_first = 1'b1;
        end
      end else begin
        model_waited();
      end
    end
  endtask

  task automatic drive_busy();
    logic [NL-1:0] b;
    b = '0;
    for (int k = 0; k < NL; k++) begin
      if (start_o[k]) begin
        act[k] = 1;
        ctr[k] = 0;
        rise[k] = use_dir ? dir_rise : int'($urandom_range(0, 3));
        fall[k] = use_dir ? dir_fall : int'($urandom_range(4, 8));
      end
      if (act[k]) begin
        if (!dead[k] && ctr[k] >= rise[k] && ctr[k] < fall[k]) b[k] = 1'b1;
        ctr[k]++;
        if (ctr[k] >= fall[k]) act[k] = 0;
      end else if (noise_en && !(m_beat && m_mask[k]) && $urandom_range(0, 5) == 0) begin
        b[k] = 1'b1;
      end
    end
    lvds_busy = b;
  endtask

  task automatic check_regs();
    chk("data_o", data_o, m_data);
    chk("start_o", start_o, m_start);
    chk("st_flag_o", st_flag_o, m_st);
    chk("end_flag_o", end_flag_o, m_end);
    chk("frame_cnt_o", frame_cnt_o, m_cnt);
    chk("err_o", err_o, m_err);
  endtask

  // One clock: drive busy, check s_ready, advance model, then check registered outputs.
  task automatic tick();
    drive_busy();
    #1;
    if (!reset) begin
      chk("s_ready", s_ready, model_ready());
      model_step();
    end
    @(negedge clk);
    if (!reset) check_regs();
  endtask

  task automatic wait_accept(input string name);
    int n;
    n = 0;
    do begin
      tick();
      n++;
    end while (!m_accepted && n < 200);
    if (!m_accepted) fail_bound(name);
  endtask

  task automatic send_beat(input logic [DW-1:0] d, input logic [NL-1:0] en, input logic last,
                           output logic [NL-1:0] st, output logic [NL-1:0] stt, output int ends);
    int n;
    s_valid = 1'b1; s_data = d; cfg_lane_en = en; s_last = last;
    ends = 0;
    wait_accept("beat_accept");
    st  = st_flag_o;
    stt = start_o;
    s_valid = 1'b0;
    cfg_lane_en = NL'($urandom_range(0, 31));
    n = 0;
    while ((m_beat || m_eof) && n < 200) begin
      tick();
      n++;
      if (end_flag_o) ends++;
    end
    if (n >= 200) fail_bound("beat_complete");
  endtask

  initial begin
    #1000000;
    $display("FAIL global_timeout actual=running required=finished");
    $fatal(1);
  end

  initial begin
    logic [NL-1:0] st, stt;
    int            e, n;

    reset = 1'b1; s_valid = 1'b0; s_data = '0; s_last = 1'b0; cfg_lane_en = '0;
    lvds_busy = '0; err_clr = 1'b0; noise_en = 0; use_dir = 0; dir_rise = 0; dir_fall = 4;
    for (int k = 0; k < NL; k++) begin
      act[k] = 0; dead[k] = 0; ctr[k] = 0; rise[k] = 0; fall[k] = 0;
    end
    model_reset();
    repeat (2) @(negedge clk);
    chk("rst_data", data_o, 0);
    chk("rst_start", start_o, 0);
    chk("rst_stflag", st_flag_o, 0);
    chk("rst_end", end_flag_o, 0);
    chk("rst_cnt", frame_cnt_o, 0);
    chk("rst_err", err_o, 0);
    reset = 1'b0;

    // Single-beat frame, busy rises 2 cycles after start and falls 8 cycles later.
    use_dir = 1; dir_rise = 2; dir_fall = 10;
    s_valid = 1'b1; s_last = 1'b1; cfg_lane_en = 5'h1F; s_data = 40'h11_22_33_44_55;
    #1 chk("t1_ready", s_ready, 1);
    tick();
    chk("t1_start", start_o, 5'h1F);
    chk("t1_stflag", st_flag_o, 5'h1F);
    chk("t1_data", data_o, 40'h11_22_33_44_55);
    s_valid = 1'b0; cfg_lane_en = 5'h02;
    for (int i = 1; i <= 11; i++) begin
      tick();
      if (i == 10) chk("t1_end_early", end_flag_o, 0);
    end
    chk("t1_end", end_flag_o, 1);
    chk("t1_cnt", frame_cnt_o, 1);
    tick();
    chk("t1_end_once", end_flag_o, 0);

    // Three-beat frame.
    use_dir = 0;
    send_beat(40'hA1A2A3A4A5, 5'h1F, 1'b0, st, stt, e);
    chk("t2_b1_st", st, 5'h1F); chk("t2_b1_start", stt, 5'h1F); chk("t2_b1_end", e, 0);
    send_beat(40'hB1B2B3B4B5, 5'h1F, 1'b0, st, stt, e);
    chk("t2_b2_st", st, 0); chk("t2_b2_start", stt, 5'h1F); chk("t2_b2_end", e, 0);
    send_beat(40'hC1C2C3C4C5, 5'h1F, 1'b1, st, stt, e);
    chk("t2_b3_st", st, 0); chk("t2_b3_start", stt, 5'h1F); chk("t2_b3_end", e, 1);
    chk("t2_cnt", frame_cnt_o, 2);

    // Partial mask; the other lanes stay idle.
    send_beat(40'h0102030405, 5'h05, 1'b1, st, stt, e);
    chk("t3_start", stt, 5'h05); chk("t3_st", st, 5'h05); chk("t3_end", e, 1);
    chk("t3_cnt", frame_cnt_o, 3);
    s_valid = 1'b1; cfg_lane_en = '0;
    #1 chk("t3_ready_nolanes", s_ready, 0);
    tick();
    s_valid = 1'b0;

    // Reset while waiting for the lanes to finish.
    use_dir = 1; dir_rise = 1; dir_fall = 10;
    s_valid = 1'b1; s_last = 1'b1; cfg_lane_en = 5'h1F; s_data = 40'hDEADBEEF01;
    wait_accept("t4_accept");
    s_valid = 1'b0;
    n = 0;
    while (!m_up && n < 50) begin
      tick();
      n++;
    end
    if (!m_up) fail_bound("t4_wait_busy");
    tick();
    reset = 1'b1;
    #1;
    chk("t4_data", data_o, 0); chk("t4_start", start_o, 0); chk("t4_stflag", st_flag_o, 0);
    chk("t4_end", end_flag_o, 0); chk("t4_cnt", frame_cnt_o, 0); chk("t4_err", err_o, 0);
    model_reset();
    tick();
    tick();
    reset = 1'b0;
    e = 0;
    for (int i = 0; i < 12; i++) begin
      tick();
      if (end_flag_o) e++;
    end
    chk("t4_no_end", e, 0);
    use_dir = 0;
    send_beat(40'h5566778899, 5'h1F, 1'b1, st, stt, e);
    chk("t4_next_st", st, 5'h1F);

    // Counter wrap.
    force dut.frame_cnt_q = 16'hFFFF;
    #1 release dut.frame_cnt_q;
    m_cnt = 16'hFFFF;
    chk("t5_preload", frame_cnt_o, 16'hFFFF);
    send_beat(40'h0F0F0F0F0F, 5'h1F, 1'b1, st, stt, e);
    chk("t5_wrap", frame_cnt_o, 16'h0000);
    chk("t5_end", e, 1);

`ifdef MAS_SCHED_TIMEOUT_EN
    // Lane 2 never goes busy: watchdog fires after 64 cycles waiting.
    use_dir = 1; dir_rise = 1; dir_fall = 6; dead[2] = 1;
    s_valid = 1'b1; s_last = 1'b1; cfg_lane_en = 5'h1F;
    wait_accept("t6_accept");
    s_valid = 1'b0;
    for (int i = 1; i <= 64; i++) tick();
    chk("t6_err_early", err_o, 0);
    tick();
    chk("t6_err", err_o, 1);
    s_valid = 1'b1; cfg_lane_en = 5'h1F;
    #1 chk("t6_ready_err", s_ready, 0);
    s_valid = 1'b0;
    repeat (3) tick();
    chk("t6_err_sticky", err_o, 1);
    err_clr = 1'b1;
    tick();
    err_clr = 1'b0;
    chk("t6_err_clr", err_o, 0);
    #1 chk("t6_ready_after", s_ready, 1);
    dead[2] = 0; use_dir = 0;
    send_beat(40'h1234567890, 5'h1F, 1'b1, st, stt, e);
    chk("t6_next_st", st, 5'h1F);
`endif

    // Randomized traffic with busy noise on idle lanes and changing lane enables.
    use_dir = 0; noise_en = 1;
    for (int i = 0; i < 2500; i++) begin
      s_valid     = ($urandom_range(0, 9) < 7);
      s_data      = DW'({$urandom(), $urandom()});
      s_last      = ($urandom_range(0, 2) == 0);
      cfg_lane_en = NL'($urandom_range(0, 31));
      tick();
    end
    s_valid = 1'b0; noise_en = 0;
    repeat (20) tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
